// File: rtl/scan_mux_seq.sv
// N-channel time-division multiplexer with a built-in channel sequencer.
// Auto mode scans enabled channels in ascending order; manual mode follows man_sel.
module scan_mux_seq #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int DWELL = 3,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SW-1:0]     man_sel,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [N_CH*W-1:0] in,
    output logic [W-1:0]      y,
    output logic [SW-1:0]     y_ch,
    output logic              y_valid,
    output logic              wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [SW-1:0] sel, sel_nx;
    logic [DW-1:0] dwell_cnt, dwell_nx;
    logic          wrap_pend, wrap_pend_nx;

    logic [SW-1:0] next_ch;
    logic          next_wraps;
    logic          found_up, found_any;
    logic          man_ok;

    // Next enabled channel above sel; otherwise the lowest enabled channel (a wrap).
    always_comb begin
        next_ch   = sel;
        found_up  = 1'b0;
        found_any = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found_up && ch_mask[i] && (SW'(i) > sel)) begin
                next_ch  = SW'(i);
                found_up = 1'b1;
            end
        end
        if (!found_up) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found_any && ch_mask[i]) begin
                    next_ch   = SW'(i);
                    found_any = 1'b1;
                end
            end
        end
        next_wraps = (next_ch <= sel);
    end

    assign man_ok = (int'(man_sel) < N_CH);

    // The wrap flag is held one cycle so it lines up with the new sel appearing on y_ch.
    always_comb begin
        sel_nx       = sel;
        dwell_nx     = dwell_cnt;
        wrap_pend_nx = wrap_pend;
        if (en) begin
            if (mode) begin
                if (man_ok) begin
                    sel_nx = man_sel;
                end
                dwell_nx     = '0;
                wrap_pend_nx = 1'b0;
            end else if (ch_mask == '0) begin
                wrap_pend_nx = 1'b0;
            end else if (!ch_mask[sel] || (dwell_cnt == DWELL_LAST)) begin
                sel_nx       = next_ch;
                dwell_nx     = '0;
                wrap_pend_nx = next_wraps;
            end else begin
                dwell_nx     = dwell_cnt + DW'(1);
                wrap_pend_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            y         <= '0;
            y_ch      <= '0;
            y_valid   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            sel       <= sel_nx;
            dwell_cnt <= dwell_nx;
            wrap_pend <= wrap_pend_nx;
            if (en) begin
                y       <= in[int'(sel)*W +: W];
                y_ch    <= sel;
                y_valid <= ch_mask[sel];
                wrap    <= wrap_pend & ~mode & (|ch_mask);
            end else begin
                y_valid <= 1'b0;
                wrap    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/scan_mux_seq.md
Name: scan_mux_seq

Overview:
Parametrised N-channel, W-bit time-division multiplexer with a built-in channel sequencer. It replaces the fixed 4:1 select-driven mux. In auto mode it scans the enabled channels in ascending order, dwelling a programmable number of cycles on each. In manual mode it tracks an external select. All outputs are registered. It sits between parallel sources and a single serial consumer, such as a shared display or logger.

Parameters:
N_CH, 4, number of input channels (>=2)
W, 1, data width per channel
DWELL, 3, cycles spent on each channel in auto mode (>=1)
SW, $clog2(N_CH), select width (derived, localparam)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance/update enable; low freezes the block
mode  input  1  0 = auto scan, 1 = manual select
man_sel  input  SW  channel used in manual mode
ch_mask  input  N_CH  1 = channel participates/valid
in  input  N_CH*W  channel k occupies in[k*W +: W]
y  output  W  registered selected data
y_ch  output  SW  channel index that y was taken from
y_valid  output  1  y is from an enabled channel
wrap  output  1  one-cycle pulse when the scan wraps to a lower index

Behaviour:
- Reset (rst_n low, asynchronous): internal sel=0, dwell_cnt=0, y=0, y_ch=0, y_valid=0, wrap=0. Reset is honoured mid-scan; after release the scan restarts at channel 0 with a full dwell.
- Output timing: at each edge with en=1, the block registers y <= in[sel], y_ch <= sel and y_valid <= ch_mask[sel]. This uses the sel value before the edge, giving a 1-cycle latency. y, y_ch and y_valid are always mutually consistent.
- en=0: sel, dwell_cnt, y and y_ch hold their values. y_valid and wrap are driven to 0.
- Auto mode (mode=0, en=1):
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt==DWELL-1, sel advances to the next channel and dwell_cnt returns to 0.
  - If the current sel is not set in ch_mask, sel advances on the next edge regardless of dwell_cnt, and dwell_cnt returns to 0.
- Next channel: the smallest index greater than sel with its mask bit set. If there is none, it is the smallest index with its mask bit set; this is a wrap.
  - On a wrap (new index <= old index), wrap is asserted for the cycle in which the new sel first appears on y_ch.
  - With a single enabled channel, sel stays put and wrap pulses every DWELL cycles.
- ch_mask all zero: sel and dwell_cnt hold, y_valid=0, wrap=0. y keeps updating from in[sel].
- Manual mode (mode=1, en=1):
  - sel <= man_sel every edge; dwell_cnt is held at 0; wrap=0.
  - Because sel and outputs are both registered, man_sel reaches y_ch two edges after being applied.
  - If man_sel >= N_CH (only possible when N_CH is not a power of 2), sel keeps its previous value.
- Mode switch manual->auto: the scan continues from the current sel with dwell_cnt=0, so that channel gets a full DWELL.
- Mode switch auto->manual: takes effect at the next edge, and dwell_cnt is cleared.
- ch_mask changes take effect at the next edge and are sampled combinationally with the next-channel search.
- Fully synchronous except reset; no combinational path from any input to any output.

Test Plan:
- N_CH=4, W=1, DWELL=3, in=4'b1101, ch_mask=4'b1111, auto, en=1 after reset -> y_ch sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0... with y=1,1,1,0,0,0,1,1,1,1,1,1,1. wrap is high exactly on the first cycle y_ch returns to 0. y_valid stays 1.
- Same setup with ch_mask=4'b0101 -> y_ch alternates 0 and 2 in 3-cycle blocks, y constant 1, wrap pulses every 6 cycles. Changing the mask to 4'b0010 while sel=0 -> sel moves to 1 and stays there; wrap pulses every 3 cycles.
- mode=1, man_sel cycled 0,1,2,3 every 3 cycles, in=4'b1101 -> y follows 1,0,1,1, lagging man_sel by 2 edges. wrap stays 0. With ch_mask=4'b1011, y_valid=0 only while y_ch=2.
- en deasserted for 5 cycles at y_ch=1, dwell_cnt=1 -> y and y_ch are frozen, y_valid=0. After en returns, channel 1 remains for exactly 2 more cycles before advancing to 2.
- rst_n pulsed low asynchronously (between clock edges) mid-scan at y_ch=2 -> outputs go to 0 immediately. After release, the scan restarts at channel 0 with a full 3-cycle dwell.
- ch_mask=4'b0000 -> y_valid stays 0, y_ch frozen, wrap=0. Restoring 4'b1000 -> scan jumps to channel 3 on the next edge, then stays there with wrap pulsing every 3 cycles.
